// File: rtl/dcache_pkg.sv
// Shared constants for the N-way write-back D-cache: default geometry, FSM state codes
// and the byte-lane merge helper used for store data.
package dcache_pkg;

  localparam int DC_INDEX_WIDTH  = 4;
  localparam int DC_OFFSET_WIDTH = 2;
  localparam int DC_WAYS         = 4;
  localparam int DC_LINE_W       = 32 << DC_OFFSET_WIDTH;
  localparam int DC_TAG_W        = 30 - DC_INDEX_WIDTH - DC_OFFSET_WIDTH;
  localparam int DC_WAY_W        = $clog2(DC_WAYS);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOOKUP  = 4'd1;
  localparam logic [3:0] S_WB_REQ  = 4'd2;
  localparam logic [3:0] S_WB_WAIT = 4'd3;
  localparam logic [3:0] S_RF_REQ  = 4'd4;
  localparam logic [3:0] S_RF_WAIT = 4'd5;
  localparam logic [3:0] S_RF_FILL = 4'd6;
  localparam logic [3:0] S_UC_REQ  = 4'd7;
  localparam logic [3:0] S_UC_WAIT = 4'd8;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_wb_way.sv
// One cache way: tag/data arrays with synchronous read and byte-enabled write,
// valid/dirty bits in flops so reset clears them asynchronously.
module dcache_wb_way
  import dcache_pkg::*;
#(
  parameter int INDEX_WIDTH = DC_INDEX_WIDTH,
  parameter int TAG_W       = DC_TAG_W,
  parameter int LINE_W      = DC_LINE_W
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rd_en_i,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic [LINE_W-1:0]      rd_data_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic                   rd_valid_o,
  output logic                   rd_dirty_o,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [LINE_W/8-1:0]    wr_be_i,
  input  logic [LINE_W-1:0]      wr_data_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic                   wr_dirty_i
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [LINE_W-1:0] data_mem [SETS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  // Array write port: data bytes gated by enables, tag rewritten on every write
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < LINE_W/8; b++) begin
        if (wr_be_i[b]) begin
          data_mem[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
      tag_mem[wr_idx_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_o <= data_mem[rd_idx_i];
      rd_tag_o  <= tag_mem[rd_idx_i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      rd_valid_o <= 1'b0;
      rd_dirty_o <= 1'b0;
    end else begin
      if (we_i) begin
        valid_q[wr_idx_i] <= 1'b1;
        dirty_q[wr_idx_i] <= wr_dirty_i;
      end
      if (rd_en_i) begin
        rd_valid_o <= valid_q[rd_idx_i];
        rd_dirty_o <= dirty_q[rd_idx_i];
      end
    end
  end

endmodule

// File: rtl/dcache_wb_nway.sv
// N-way set-associative write-back/write-allocate L1 D-cache: lookup FSM, per-set
// round-robin victim choice, dirty write-back, single-word uncached bypass.
module dcache_wb_nway
  import dcache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DC_OFFSET_WIDTH,
  parameter int WAYS         = DC_WAYS,
  localparam int LINE_W      = 32 << OFFSET_WIDTH
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       addr_pipeline_dcache,
  input  logic [31:0]       paddr_pipeline_dcache,
  input  logic [31:0]       din_pipeline_dcache,
  input  logic              type_pipeline_dcache,
  input  logic [3:0]        pipeline_dcache_wstrb,
  input  logic              pipeline_dcache_uncached,
  input  logic              pipeline_dcache_valid,
  output logic              dcache_pipeline_ready,
  output logic [31:0]       dout_dcache_pipeline,
  output logic              dcache_pipeline_rvalid,
  output logic [31:0]       addr_dcache_mem,
  output logic [LINE_W-1:0] dout_dcache_mem,
  input  logic [LINE_W-1:0] din_mem_dcache,
  output logic              dcache_mem_req,
  output logic              dcache_mem_wr,
  output logic              dcache_mem_line,
  output logic [3:0]        dcache_mem_wstrb,
  input  logic              mem_dcache_addrOK,
  input  logic              mem_dcache_dataOK,
  input  logic              mem_dcache_bvalid
);

  localparam int TAG_W  = 30 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORDS  = 1 << OFFSET_WIDTH;
  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int IDX_LO = OFFSET_WIDTH + 2;
  localparam int TAG_LO = IDX_LO + INDEX_WIDTH;

  logic [3:0]              state_q, state_d;
  logic [INDEX_WIDTH-1:0]  idx_q;
  logic [31:0]             paddr_q, din_q;
  logic [3:0]              wstrb_q;
  logic                    type_q, unc_q;
  logic [WAY_W-1:0]        victim_q, victim_s, hit_way_s, wr_way_s;
  logic [WAY_W-1:0]        rr_q [SETS];
  logic [LINE_W-1:0]       line_q, fill_line_s, hit_line_s, wr_data_s;
  logic [LINE_W-1:0]       way_rdata_s [WAYS];
  logic [TAG_W-1:0]        way_rtag_s [WAYS];
  logic [WAYS-1:0]         way_rvalid_s, way_rdirty_s, hit_vec_s;
  logic [LINE_W/8-1:0]     wr_be_s;
  logic [TAG_W-1:0]        wr_tag_s, ptag_s;
  logic [OFFSET_WIDTH-1:0] off_s, off_q;
  logic                    we_s, wr_dirty_s, accept_s, ready_s, hit_s;
  logic                    ld_hit_s, st_hit_s, capture_s, uc_done_s;
  logic                    unused_addr_s;

  assign ptag_s        = paddr_pipeline_dcache[31:TAG_LO];
  assign off_s         = paddr_pipeline_dcache[IDX_LO-1:2];
  assign off_q         = paddr_q[IDX_LO-1:2];
  assign unused_addr_s = ^{addr_pipeline_dcache[31:TAG_LO], addr_pipeline_dcache[IDX_LO-1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_wb_way #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
      .clk        (clk),
      .rstn       (rstn),
      .rd_en_i    (accept_s),
      .rd_idx_i   (addr_pipeline_dcache[TAG_LO-1:IDX_LO]),
      .rd_data_o  (way_rdata_s[w]),
      .rd_tag_o   (way_rtag_s[w]),
      .rd_valid_o (way_rvalid_s[w]),
      .rd_dirty_o (way_rdirty_s[w]),
      .we_i       (we_s && (wr_way_s == WAY_W'(w))),
      .wr_idx_i   (idx_q),
      .wr_be_i    (wr_be_s),
      .wr_data_i  (wr_data_s),
      .wr_tag_i   (wr_tag_s),
      .wr_dirty_i (wr_dirty_s)
    );
    assign hit_vec_s[w] = way_rvalid_s[w] && (way_rtag_s[w] == ptag_s);
  end

  assign hit_s      = |hit_vec_s;
  assign ld_hit_s   = (state_q == S_LOOKUP) && !unc_q && !type_q && hit_s;
  assign st_hit_s   = (state_q == S_LOOKUP) && !unc_q && type_q && hit_s;
  assign ready_s    = rstn && ((state_q == S_IDLE) || ld_hit_s);
  assign accept_s   = pipeline_dcache_valid && ready_s;
  assign capture_s  = mem_dcache_dataOK &&
                      (((state_q == S_RF_REQ) && mem_dcache_addrOK) || (state_q == S_RF_WAIT));
  assign uc_done_s  = type_q ? mem_dcache_bvalid : mem_dcache_dataOK;
  assign hit_line_s = way_rdata_s[hit_way_s];
  assign dcache_pipeline_ready = ready_s;

  // Hit way encode and victim pick: lowest invalid way wins over the round-robin pointer
  always_comb begin
    hit_way_s = '0;
    victim_s  = rr_q[idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
      victim_s  = way_rvalid_s[w] ? victim_s : WAY_W'(w);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = accept_s ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        if (unc_q) begin
          state_d = S_UC_REQ;
        end else if (hit_s) begin
          state_d = accept_s ? S_LOOKUP : S_IDLE;
        end else if (way_rvalid_s[victim_s] && way_rdirty_s[victim_s]) begin
          state_d = S_WB_REQ;
        end else begin
          state_d = S_RF_REQ;
        end
      end
      S_WB_REQ:  state_d = mem_dcache_addrOK ? (mem_dcache_bvalid ? S_RF_REQ : S_WB_WAIT) : S_WB_REQ;
      S_WB_WAIT: state_d = mem_dcache_bvalid ? S_RF_REQ : S_WB_WAIT;
      S_RF_REQ:  state_d = mem_dcache_addrOK ? (mem_dcache_dataOK ? S_RF_FILL : S_RF_WAIT) : S_RF_REQ;
      S_RF_WAIT: state_d = mem_dcache_dataOK ? S_RF_FILL : S_RF_WAIT;
      S_RF_FILL: state_d = S_IDLE;
      S_UC_REQ:  state_d = mem_dcache_addrOK ? (uc_done_s ? S_IDLE : S_UC_WAIT) : S_UC_REQ;
      S_UC_WAIT: state_d = uc_done_s ? S_IDLE : S_UC_WAIT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      paddr_q  <= '0;
      din_q    <= '0;
      wstrb_q  <= '0;
      type_q   <= 1'b0;
      unc_q    <= 1'b0;
      victim_q <= '0;
      line_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        idx_q   <= addr_pipeline_dcache[TAG_LO-1:IDX_LO];
        din_q   <= din_pipeline_dcache;
        wstrb_q <= pipeline_dcache_wstrb;
        type_q  <= type_pipeline_dcache;
        unc_q   <= pipeline_dcache_uncached;
      end
      if (state_q == S_LOOKUP) begin
        paddr_q <= paddr_pipeline_dcache;
        if (!unc_q && !hit_s) begin
          victim_q    <= victim_s;
          rr_q[idx_q] <= rr_q[idx_q] + WAY_W'(1);
        end
      end
      if (capture_s) begin
        line_q <= din_mem_dcache;
      end
    end
  end

  // Refill line with the pending store merged into its word
  always_comb begin
    fill_line_s = line_q;
    if (type_q) begin
      fill_line_s[32*off_q +: 32] = merge_word(line_q[32*off_q +: 32], din_q, wstrb_q);
    end else begin
      fill_line_s = line_q;
    end
  end

  always_comb begin
    we_s       = 1'b0;
    wr_way_s   = '0;
    wr_be_s    = '0;
    wr_data_s  = '0;
    wr_tag_s   = paddr_q[31:TAG_LO];
    wr_dirty_s = 1'b0;
    if (st_hit_s) begin
      we_s                 = 1'b1;
      wr_way_s             = hit_way_s;
      wr_be_s[4*off_s +: 4] = wstrb_q;
      wr_data_s            = {WORDS{din_q}};
      wr_tag_s             = ptag_s;
      wr_dirty_s           = 1'b1;
    end else if (state_q == S_RF_FILL) begin
      we_s       = 1'b1;
      wr_way_s   = victim_q;
      wr_be_s    = '1;
      wr_data_s  = fill_line_s;
      wr_dirty_s = type_q;
    end else begin
      we_s = 1'b0;
    end
  end

  always_comb begin
    dcache_pipeline_rvalid = 1'b0;
    dout_dcache_pipeline   = '0;
    if (ld_hit_s) begin
      dcache_pipeline_rvalid = 1'b1;
      dout_dcache_pipeline   = hit_line_s[32*off_s +: 32];
    end else if ((state_q == S_RF_FILL) && !type_q) begin
      dcache_pipeline_rvalid = 1'b1;
      dout_dcache_pipeline   = line_q[32*off_q +: 32];
    end else if (!type_q && mem_dcache_dataOK &&
                 (((state_q == S_UC_REQ) && mem_dcache_addrOK) || (state_q == S_UC_WAIT))) begin
      dcache_pipeline_rvalid = 1'b1;
      dout_dcache_pipeline   = din_mem_dcache[31:0];
    end else begin
      dcache_pipeline_rvalid = 1'b0;
    end
  end

  always_comb begin
    dcache_mem_req   = 1'b0;
    dcache_mem_wr    = 1'b0;
    dcache_mem_line  = 1'b0;
    dcache_mem_wstrb = 4'h0;
    addr_dcache_mem  = 32'h0;
    dout_dcache_mem  = '0;
    case (state_q)
      S_WB_REQ: begin
        dcache_mem_req   = 1'b1;
        dcache_mem_wr    = 1'b1;
        dcache_mem_line  = 1'b1;
        dcache_mem_wstrb = 4'hF;
        addr_dcache_mem  = {way_rtag_s[victim_q], idx_q, {IDX_LO{1'b0}}};
        dout_dcache_mem  = way_rdata_s[victim_q];
      end
      S_RF_REQ: begin
        dcache_mem_req   = 1'b1;
        dcache_mem_line  = 1'b1;
        dcache_mem_wstrb = 4'hF;
        addr_dcache_mem  = {paddr_q[31:TAG_LO], idx_q, {IDX_LO{1'b0}}};
      end
      S_UC_REQ: begin
        dcache_mem_req   = 1'b1;
        dcache_mem_wr    = type_q;
        dcache_mem_wstrb = type_q ? wstrb_q : 4'hF;
        addr_dcache_mem  = paddr_q;
        dout_dcache_mem  = LINE_W'(din_q);
      end
      default: dcache_mem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb_nway.sv
// Directed bench for dcache_wb_nway (default 16 sets x 4 ways x 128-bit lines); the bench
// plays the memory side cycle by cycle and checks hand-computed results.
module tb_dcache_wb_nway;

  logic         clk, rstn;
  logic [31:0]  addr_pipeline_dcache, paddr_pipeline_dcache, din_pipeline_dcache;
  logic         type_pipeline_dcache;
  logic [3:0]   pipeline_dcache_wstrb;
  logic         pipeline_dcache_uncached, pipeline_dcache_valid;
  logic         dcache_pipeline_ready;
  logic [31:0]  dout_dcache_pipeline;
  logic         dcache_pipeline_rvalid;
  logic [31:0]  addr_dcache_mem;
  logic [127:0] dout_dcache_mem, din_mem_dcache;
  logic         dcache_mem_req, dcache_mem_wr, dcache_mem_line;
  logic [3:0]   dcache_mem_wstrb;
  logic         mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] LINE_A     = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] LINE_A_MOD = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_1234, 32'hAAAA_AAAA};

  dcache_wb_nway dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .addr_pipeline_dcache     (addr_pipeline_dcache),
    .paddr_pipeline_dcache    (paddr_pipeline_dcache),
    .din_pipeline_dcache      (din_pipeline_dcache),
    .type_pipeline_dcache     (type_pipeline_dcache),
    .pipeline_dcache_wstrb    (pipeline_dcache_wstrb),
    .pipeline_dcache_uncached (pipeline_dcache_uncached),
    .pipeline_dcache_valid    (pipeline_dcache_valid),
    .dcache_pipeline_ready    (dcache_pipeline_ready),
    .dout_dcache_pipeline     (dout_dcache_pipeline),
    .dcache_pipeline_rvalid   (dcache_pipeline_rvalid),
    .addr_dcache_mem          (addr_dcache_mem),
    .dout_dcache_mem          (dout_dcache_mem),
    .din_mem_dcache           (din_mem_dcache),
    .dcache_mem_req           (dcache_mem_req),
    .dcache_mem_wr            (dcache_mem_wr),
    .dcache_mem_line          (dcache_mem_line),
    .dcache_mem_wstrb         (dcache_mem_wstrb),
    .mem_dcache_addrOK        (mem_dcache_addrOK),
    .mem_dcache_dataOK        (mem_dcache_dataOK),
    .mem_dcache_bvalid        (mem_dcache_bvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns in the LOOKUP cycle with paddr applied
  task automatic issue(input logic [31:0] a, input logic wr, input logic [3:0] strb,
                       input logic [31:0] d, input logic unc);
    addr_pipeline_dcache     = a;
    type_pipeline_dcache     = wr;
    pipeline_dcache_wstrb    = strb;
    din_pipeline_dcache      = d;
    pipeline_dcache_uncached = unc;
    pipeline_dcache_valid    = 1'b1;
    tick();
    pipeline_dcache_valid = 1'b0;
    paddr_pipeline_dcache = a;
    #1;
  endtask

  // Called in RF_REQ; returns in RF_FILL
  task automatic refill(input string tg, input logic [127:0] ln, input logic same);
    din_mem_dcache = ln;
    if (same) begin
      mem_dcache_addrOK = 1'b1;
      mem_dcache_dataOK = 1'b1;
      #1;
      check({tg, " no early rvalid"}, 128'(dcache_pipeline_rvalid), 128'd0);
      tick();
      mem_dcache_addrOK = 1'b0;
      mem_dcache_dataOK = 1'b0;
    end else begin
      mem_dcache_addrOK = 1'b1;
      tick();
      mem_dcache_addrOK = 1'b0;
      #1;
      check({tg, " rf_wait req"}, 128'(dcache_mem_req), 128'd0);
      mem_dcache_dataOK = 1'b1;
      tick();
      mem_dcache_dataOK = 1'b0;
    end
    #1;
  endtask

  task automatic miss_load(input string tg, input logic [31:0] a, input logic [127:0] ln,
                           input logic same, input logic [31:0] exp_word);
    issue(a, 1'b0, 4'h0, 32'h0, 1'b0);
    check({tg, " miss rvalid"}, 128'(dcache_pipeline_rvalid), 128'd0);
    tick();
    check({tg, " rf req/wr/line"}, 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b101));
    check({tg, " rf addr"}, 128'(addr_dcache_mem), 128'(a & 32'hFFFF_FFF0));
    refill(tg, ln, same);
    check({tg, " fill rvalid"}, 128'(dcache_pipeline_rvalid), 128'd1);
    check({tg, " fill dout"}, 128'(dout_dcache_pipeline), 128'(exp_word));
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    addr_pipeline_dcache = '0; paddr_pipeline_dcache = '0; din_pipeline_dcache = '0;
    type_pipeline_dcache = 1'b0; pipeline_dcache_wstrb = 4'h0;
    pipeline_dcache_uncached = 1'b0; pipeline_dcache_valid = 1'b0;
    din_mem_dcache = '0; mem_dcache_addrOK = 1'b0; mem_dcache_dataOK = 1'b0; mem_dcache_bvalid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 128'(dcache_pipeline_ready), 128'd0);
    check("rst req/wr/line", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'd0);
    check("rst rvalid", 128'(dcache_pipeline_rvalid), 128'd0);
    check("rst wstrb", 128'(dcache_mem_wstrb), 128'd0);
    rstn = 1'b1;
    #1;
    check("idle ready", 128'(dcache_pipeline_ready), 128'd1);

    // Cold load, then store hit merging bytes 0..1
    miss_load("cold", 32'h1000_0004, LINE_A, 1'b0, 32'hBBBB_BBBB);
    issue(32'h1000_0004, 1'b1, 4'b0011, 32'h0000_1234, 1'b0);
    check("st hit ready", 128'(dcache_pipeline_ready), 128'd0);
    check("st hit req", 128'(dcache_mem_req), 128'd0);
    tick();
    check("st done ready", 128'(dcache_pipeline_ready), 128'd1);

    // Back-to-back load hits, second accepted in the first's lookup cycle
    addr_pipeline_dcache = 32'h1000_0004; type_pipeline_dcache = 1'b0;
    pipeline_dcache_uncached = 1'b0; pipeline_dcache_valid = 1'b1;
    tick();
    paddr_pipeline_dcache = 32'h1000_0004;
    addr_pipeline_dcache  = 32'h1000_0008;
    #1;
    check("b2b1 rvalid", 128'(dcache_pipeline_rvalid), 128'd1);
    check("b2b1 dout", 128'(dout_dcache_pipeline), 128'h0000_0000_0000_0000_0000_0000_BBBB_1234);
    check("b2b1 ready", 128'(dcache_pipeline_ready), 128'd1);
    tick();
    pipeline_dcache_valid = 1'b0;
    paddr_pipeline_dcache = 32'h1000_0008;
    #1;
    check("b2b2 rvalid", 128'(dcache_pipeline_rvalid), 128'd1);
    check("b2b2 dout", 128'(dout_dcache_pipeline), 128'(32'hCCCC_CCCC));
    tick();

    // Fill the rest of set 0; the 0x3000 fill gets addrOK and dataOK together
    miss_load("w1", 32'h2000_0000, mk_line(32'h2000_0000), 1'b0, 32'h2000_0000);
    miss_load("w2", 32'h3000_0008, mk_line(32'h3000_0000), 1'b1, 32'h3000_0002);
    miss_load("w3", 32'h4000_0000, mk_line(32'h4000_0000), 1'b0, 32'h4000_0000);

    // Fifth tag evicts dirty way 0
    issue(32'h5000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    check("evict miss rvalid", 128'(dcache_pipeline_rvalid), 128'd0);
    tick();
    check("wb req/wr/line", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b111));
    check("wb addr", 128'(addr_dcache_mem), 128'(32'h1000_0000));
    check("wb wstrb", 128'(dcache_mem_wstrb), 128'(4'hF));
    check("wb data", dout_dcache_mem, LINE_A_MOD);
    mem_dcache_addrOK = 1'b1;
    tick();
    mem_dcache_addrOK = 1'b0;
    #1;
    check("wb_wait req", 128'(dcache_mem_req), 128'd0);
    mem_dcache_bvalid = 1'b1;
    tick();
    mem_dcache_bvalid = 1'b0;
    #1;
    check("evict rf req/wr/line", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b101));
    check("evict rf addr", 128'(addr_dcache_mem), 128'(32'h5000_0000));
    refill("evict", mk_line(32'h5000_0000), 1'b0);
    check("evict fill dout", 128'(dout_dcache_pipeline), 128'(32'h5000_0000));
    tick();

    // Uncached load bypasses cache, data returned in the dataOK cycle
    issue(32'h1FD0_0000, 1'b0, 4'h0, 32'h0, 1'b1);
    check("ucl lookup rvalid", 128'(dcache_pipeline_rvalid), 128'd0);
    tick();
    check("ucl req/wr/line", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b100));
    check("ucl wstrb", 128'(dcache_mem_wstrb), 128'(4'hF));
    check("ucl addr", 128'(addr_dcache_mem), 128'(32'h1FD0_0000));
    din_mem_dcache = 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D;
    mem_dcache_addrOK = 1'b1;
    mem_dcache_dataOK = 1'b1;
    #1;
    check("ucl rvalid", 128'(dcache_pipeline_rvalid), 128'd1);
    check("ucl dout", 128'(dout_dcache_pipeline), 128'(32'hCAFE_F00D));
    tick();
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;
    #1;
    check("ucl done ready", 128'(dcache_pipeline_ready), 128'd1);

    // Uncached store to a cached address must not touch the cached copy
    issue(32'h5000_0004, 1'b1, 4'b0001, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("ucs req/wr/line", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b110));
    check("ucs wstrb", 128'(dcache_mem_wstrb), 128'(4'b0001));
    check("ucs addr", 128'(addr_dcache_mem), 128'(32'h5000_0004));
    check("ucs data", 128'(dout_dcache_mem[31:0]), 128'(32'hFFFF_FFFF));
    mem_dcache_addrOK = 1'b1;
    tick();
    mem_dcache_addrOK = 1'b0;
    #1;
    check("ucs wait req", 128'(dcache_mem_req), 128'd0);
    mem_dcache_bvalid = 1'b1;
    tick();
    mem_dcache_bvalid = 1'b0;
    #1;
    check("ucs done ready", 128'(dcache_pipeline_ready), 128'd1);
    issue(32'h5000_0004, 1'b0, 4'h0, 32'h0, 1'b0);
    check("post-uc hit rvalid", 128'(dcache_pipeline_rvalid), 128'd1);
    check("post-uc hit dout", 128'(dout_dcache_pipeline), 128'(32'h5000_0001));
    tick();

    // 0x1000 was evicted: round-robin now points at clean way 1, so straight refill
    miss_load("rr", 32'h1000_0000, mk_line(32'h1100_0000), 1'b0, 32'h1100_0000);

    // Reset in RF_WAIT drops req at once and invalidates every line
    issue(32'h6000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();
    mem_dcache_addrOK = 1'b1;
    tick();
    mem_dcache_addrOK = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst req", 128'(dcache_mem_req), 128'd0);
    check("midrst ready", 128'(dcache_pipeline_ready), 128'd0);
    #2;
    rstn = 1'b1;
    tick();
    check("postrst ready", 128'(dcache_pipeline_ready), 128'd1);
    issue(32'h5000_0004, 1'b0, 4'h0, 32'h0, 1'b0);
    check("postrst miss rvalid", 128'(dcache_pipeline_rvalid), 128'd0);
    tick();
    check("postrst rf req", 128'({dcache_mem_req, dcache_mem_wr, dcache_mem_line}), 128'(3'b101));
    check("postrst rf addr", 128'(addr_dcache_mem), 128'(32'h5000_0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
